// File: rtl/imem_boot_loader_pkg.sv
// Shared widths, FSM state encoding and helpers for the instruction-memory boot loader.
// Width defaults come from IMEM_ADDR_WIDTH / IMEM_DATA_WIDTH when the build does not set them.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 8
`endif
`ifndef IMEM_DATA_WIDTH
`define IMEM_DATA_WIDTH 16
`endif

package imem_boot_loader_pkg;

   localparam int unsigned IMEM_AW = `IMEM_ADDR_WIDTH;
   localparam int unsigned IMEM_DW = `IMEM_DATA_WIDTH;
   localparam int unsigned HDR_W   = 16;

   typedef enum logic [2:0] {
      ST_LEN_LO = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_DATA   = 3'd2,
      ST_DONE   = 3'd3,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      ST_CSUM   = 3'd4,
      ST_ERROR  = 3'd5,
`endif
      ST_RUN    = 3'd6
   } state_e;

   // Byte-lane counter width; never zero so single-byte words still get a legal vector.
   function automatic int unsigned lane_width(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host byte-stream and CPU instruction-fetch signals of the boot loader.
// master = host link / CPU side, slave = loader.
interface imem_boot_loader_if
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = IMEM_AW,
   parameter int unsigned DATA_WIDTH = IMEM_DW
);
   logic [7:0]            load_data;
   logic                  load_valid;
   logic                  load_ready;
   logic                  reload;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_value;

   modport master (
      output load_data, load_valid, reload, imem_addr,
      input  load_ready, imem_value
   );

   modport slave (
      input  load_data, load_valid, reload, imem_addr,
      output load_ready, imem_value
   );
endinterface

// File: rtl/imem_boot_loader_storage.sv
// Instruction array: one synchronous write port, one combinational read port.
// Contents are never cleared; the loader masks stale words on the read side.
module imem_boot_loader_storage #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata_c
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata_c = r_mem[i_raddr];
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed program over a byte stream, holds the CPU in reset
// until it is stored, then serves fetches. IMEM_BOOT_LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = IMEM_AW,
   parameter int unsigned DATA_WIDTH = IMEM_DW
) (
   input  logic               clock,
   input  logic               reset,
   imem_boot_loader_if.slave  bus,
   output logic               cpu_nreset,
   output logic [HDR_W-1:0]   loaded_words,
   output logic               overflow,
   output logic               load_error
);
   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam int unsigned LANES  = DATA_WIDTH / 8;
   localparam int unsigned LANE_W = lane_width(LANES);

   state_e                r_state;
   logic                  r_load_ready;
   logic                  r_cpu_nreset;
   logic [LANE_W-1:0]     r_lane;
   logic [HDR_W-1:0]      r_wcnt;
   logic [HDR_W-1:0]      r_loaded_words;
   logic [7:0]            r_len_lo;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_overflow;

   logic                  w_xfer;
   logic                  w_restart;
   logic                  w_last_lane;
   logic                  w_last_word;
   logic                  w_we;
   logic [HDR_W-1:0]      w_len;
   logic [DATA_WIDTH-1:0] w_word;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_hit;

   assign w_xfer      = bus.load_valid && r_load_ready;
   assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
   assign w_last_word = ((32'(r_wcnt) + 32'd1) == 32'(r_loaded_words));
   assign w_len       = {bus.load_data, r_len_lo};
   // Words beyond the array are consumed but dropped rather than wrapping onto low addresses.
   assign w_we        = w_xfer && (r_state == ST_DATA) && w_last_lane
                        && (32'(r_wcnt) < 32'(DEPTH));

   if (LANES == 1) begin : g_byte_word
      assign w_word = bus.load_data;
   end else begin : g_wide_word
      assign w_word = {bus.load_data, r_shift[DATA_WIDTH-1:8]};
   end

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
   logic       r_load_error;
   logic [7:0] r_csum;

   assign w_restart  = reset || (bus.reload && ((r_state == ST_RUN) || (r_state == ST_ERROR)));
   assign load_error = r_load_error;
`else
   assign w_restart  = reset || (bus.reload && (r_state == ST_RUN));
   assign load_error = 1'b0;
`endif

   // Load FSM; reset and reload share the same clearing path.
   always_ff @(posedge clock) begin
      if (w_restart) begin
         r_state        <= ST_LEN_LO;
         r_load_ready   <= 1'b1;
         r_cpu_nreset   <= 1'b0;
         r_lane         <= '0;
         r_wcnt         <= '0;
         r_loaded_words <= '0;
         r_overflow     <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
         r_load_error   <= 1'b0;
         r_csum         <= '0;
`endif
      end else begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
         if (w_xfer && (r_state != ST_CSUM)) r_csum <= r_csum ^ bus.load_data;
`endif
         case (r_state)
            ST_LEN_LO: begin
               if (w_xfer) begin
                  r_len_lo <= bus.load_data;
                  r_state  <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (w_xfer) begin
                  r_loaded_words <= w_len;
                  r_overflow     <= (32'(w_len) > 32'(DEPTH));
                  if (w_len == '0) begin
                     r_state      <= ST_DONE;
                     r_load_ready <= 1'b0;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_xfer) begin
                  r_shift <= w_word;
                  r_lane  <= w_last_lane ? '0 : r_lane + LANE_W'(1);
                  if (w_last_lane) begin
                     r_wcnt <= r_wcnt + HDR_W'(1);
                     if (w_last_word) begin
                        r_state      <= ST_DONE;
                        r_load_ready <= 1'b0;
                     end
                  end
               end
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            ST_DONE: begin
               r_state      <= ST_CSUM;
               r_load_ready <= 1'b1;
            end
            ST_CSUM: begin
               if (w_xfer) begin
                  r_load_ready <= 1'b0;
                  if (bus.load_data == r_csum) begin
                     r_state      <= ST_RUN;
                     r_cpu_nreset <= 1'b1;
                  end else begin
                     r_state      <= ST_ERROR;
                     r_load_error <= 1'b1;
                  end
               end
            end
            ST_ERROR: r_state <= ST_ERROR;
`else
            ST_DONE: begin
               r_state      <= ST_RUN;
               r_cpu_nreset <= 1'b1;
            end
`endif
            ST_RUN: r_state <= ST_RUN;
            default: begin
               r_state      <= ST_LEN_LO;
               r_load_ready <= 1'b1;
               r_cpu_nreset <= 1'b0;
            end
         endcase
      end
   end

   imem_boot_loader_storage #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_storage (
      .clock     (clock),
      .i_we      (w_we),
      .i_waddr   (ADDR_WIDTH'(r_wcnt)),
      .i_wdata   (w_word),
      .i_raddr   (bus.imem_addr),
      .o_rdata_c (w_rdata)
   );

   // Addresses at or past the header count read as zero, hiding stale contents.
   assign w_hit          = (r_state == ST_RUN) && (32'(bus.imem_addr) < 32'(r_loaded_words));
   assign bus.imem_value = w_hit ? w_rdata : '0;
   assign bus.load_ready = r_load_ready;
   assign cpu_nreset     = r_cpu_nreset;
   assign loaded_words   = r_loaded_words;
   assign overflow       = r_overflow;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a 256x16 instance plus a 4x16 instance for overflow.
module tb_imem_boot_loader;
   import imem_boot_loader_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        nres, ovf, lerr;
   logic        nres_ov, ovf_ov, lerr_ov;
   logic [15:0] lw, lw_ov;
   logic [7:0]  tb_xor;
   int          errors = 0;
   int          checks = 0;

   always #5 clock = ~clock;

   imem_boot_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();
   imem_boot_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) bus_ov ();

   imem_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus),
      .cpu_nreset   (nres),
      .loaded_words (lw),
      .overflow     (ovf),
      .load_error   (lerr)
   );

   imem_boot_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) dut_ov (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus_ov),
      .cpu_nreset   (nres_ov),
      .loaded_words (lw_ov),
      .overflow     (ovf_ov),
      .load_error   (lerr_ov)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the byte's transfer edge.
   task automatic send(input bit ov, input logic [7:0] b);
      int   budget;
      logic rdy;
      budget = 0;
      if (ov) begin bus_ov.load_data = b; bus_ov.load_valid = 1'b1; end
      else    begin bus.load_data    = b; bus.load_valid    = 1'b1; end
      do begin
         rdy = ov ? bus_ov.load_ready : bus.load_ready;
         @(negedge clock);
         budget++;
      end while (!rdy && budget < 20);
      if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
      tb_xor ^= b;
      if (ov) bus_ov.load_valid = 1'b0;
      else    bus.load_valid    = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.load_valid = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   // Release timing after the last stream byte; imem_addr must already be 0.
   task automatic finish_load(input bit ov);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      logic [7:0] c;
      c = tb_xor;
      send(ov, c);
      check("nreset_after_csum", 32'(ov ? nres_ov : nres), 32'd1);
`else
      check("nreset_in_done", 32'(ov ? nres_ov : nres), 32'd0);
      check("value_before_run", 32'(ov ? bus_ov.imem_value : bus.imem_value), 32'd0);
      @(negedge clock);
      check("nreset_run", 32'(ov ? nres_ov : nres), 32'd1);
`endif
   endtask

   task automatic do_reload();
      bus.reload = 1'b1;
      @(negedge clock);
      bus.reload = 1'b0;
      check("reload_nreset", 32'(nres), 32'd0);
      check("reload_ready", 32'(bus.load_ready), 32'd1);
      check("reload_words", 32'(lw), 32'd0);
      tb_xor = 8'h00;
   endtask

   task automatic read(input string tag, input logic [7:0] a, input logic [15:0] exp);
      bus.imem_addr = a;
      #1;
      check(tag, 32'(bus.imem_value), 32'(exp));
   endtask

   logic [7:0] s1 [6] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};

   initial begin
      reset = 1'b1;
      tb_xor = 8'h00;
      bus.load_data = '0;    bus.load_valid = 1'b0;    bus.reload = 1'b0;    bus.imem_addr = '0;
      bus_ov.load_data = '0; bus_ov.load_valid = 1'b0; bus_ov.reload = 1'b0; bus_ov.imem_addr = '0;
      repeat (3) @(negedge clock);
      check("rst_nreset", 32'(nres), 32'd0);
      check("rst_ready", 32'(bus.load_ready), 32'd1);
      check("rst_words", 32'(lw), 32'd0);
      check("rst_overflow", 32'(ovf), 32'd0);
      check("rst_load_error", 32'(lerr), 32'd0);
      check("rst_value", 32'(bus.imem_value), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Basic load
      for (int i = 0; i < 6; i++) send(1'b0, s1[i]);
      finish_load(1'b0);
      read("basic_a0", 8'd0, 16'h1234);
      read("basic_a1", 8'd1, 16'h5678);
      read("basic_a2", 8'd2, 16'h0000);
      check("basic_words", 32'(lw), 32'd2);
      check("basic_ready_run", 32'(bus.load_ready), 32'd0);
      check("basic_overflow", 32'(ovf), 32'd0);
      bus.imem_addr = '0;
      @(negedge clock);

      // Same stream with random stalls
      do_reload();
      for (int i = 0; i < 6; i++) begin
         idle(int'($urandom_range(0, 3)));
         send(1'b0, s1[i]);
      end
      finish_load(1'b0);
      read("stall_a0", 8'd0, 16'h1234);
      read("stall_a1", 8'd1, 16'h5678);
      check("stall_words", 32'(lw), 32'd2);
      check("stall_ready_run", 32'(bus.load_ready), 32'd0);
      bus.imem_addr = '0;
      @(negedge clock);

      // Empty program: stale words stay hidden
      do_reload();
      send(1'b0, 8'h00);
      send(1'b0, 8'h00);
      finish_load(1'b0);
      read("empty_a0", 8'd0, 16'h0000);
      read("empty_a1", 8'd1, 16'h0000);
      read("empty_a255", 8'd255, 16'h0000);
      check("empty_words", 32'(lw), 32'd0);
      bus.imem_addr = '0;
      @(negedge clock);

      // Reset in the middle of a load abandons it
      do_reload();
      send(1'b0, 8'h05);
      send(1'b0, 8'h00);
      send(1'b0, 8'hEF);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      tb_xor = 8'h00;
      check("midrst_ready", 32'(bus.load_ready), 32'd1);
      check("midrst_words", 32'(lw), 32'd0);
      check("midrst_nreset", 32'(nres), 32'd0);
      send(1'b0, 8'h01);
      send(1'b0, 8'h00);
      send(1'b0, 8'hCD);
      send(1'b0, 8'hAB);
      finish_load(1'b0);
      read("midrst_a0", 8'd0, 16'hABCD);
      read("midrst_a1", 8'd1, 16'h0000);
      check("midrst_words_run", 32'(lw), 32'd1);
      bus.imem_addr = '0;
      @(negedge clock);

      // Overflow on the 4-word instance
      tb_xor = 8'h00;
      send(1'b1, 8'h05);
      send(1'b1, 8'h00);
      check("ovf_flag_hdr", 32'(ovf_ov), 32'd1);
      for (int w = 1; w <= 5; w++) begin
         send(1'b1, 8'(w));
         send(1'b1, 8'h00);
      end
      finish_load(1'b1);
      bus_ov.imem_addr = 2'd3;
      #1;
      check("ovf_a3", 32'(bus_ov.imem_value), 32'h0004);
      bus_ov.imem_addr = 2'd0;
      #1;
      check("ovf_a0", 32'(bus_ov.imem_value), 32'h0001);
      check("ovf_words", 32'(lw_ov), 32'd5);
      check("ovf_flag_run", 32'(ovf_ov), 32'd1);
      @(negedge clock);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      // Checksum match then mismatch
      do_reload();
      send(1'b0, 8'h01); send(1'b0, 8'h00); send(1'b0, 8'hCD); send(1'b0, 8'hAB);
      send(1'b0, 8'h67);
      check("csum_ok_nreset", 32'(nres), 32'd1);
      check("csum_ok_error", 32'(lerr), 32'd0);
      read("csum_ok_a0", 8'd0, 16'hABCD);
      bus.imem_addr = '0;
      @(negedge clock);
      do_reload();
      send(1'b0, 8'h01); send(1'b0, 8'h00); send(1'b0, 8'hCD); send(1'b0, 8'hAB);
      send(1'b0, 8'h00);
      @(negedge clock);
      check("csum_bad_error", 32'(lerr), 32'd1);
      check("csum_bad_nreset", 32'(nres), 32'd0);
      check("csum_bad_ready", 32'(bus.load_ready), 32'd0);
      do_reload();
      check("csum_reload_error", 32'(lerr), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
